// File: rtl/timed_cmd_scheduler.sv
// Timed command scheduler: pops timestamped commands, waits for the timer, then runs one bus cycle.
// Optional late-command dropping is enabled with `define TIMED_CMD_SCHED_LATE_DROP_EN.
module timed_cmd_scheduler #(
  parameter int TIME_W      = 32,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 16,
  parameter int CMD_W       = TIME_W + 1 + ADDR_W + DATA_W,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 16
`ifdef TIMED_CMD_SCHED_LATE_DROP_EN
  , parameter int LATE_SLACK = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [TIME_W-1:0] current_time,
  output logic              reset_time,
  input  logic [CMD_W-1:0]  cmd_fifo_dout,
  input  logic              cmd_fifo_empty,
  input  logic              cmd_fifo_valid,
  output logic              cmd_fifo_rd_en,
  output logic [ADDR_W-1:0] cmd_bus_addr,
  output logic [DATA_W-1:0] cmd_bus_data,
  output logic              cmd_bus_en,
  output logic              cmd_bus_wr,
  output logic              cmd_bus_rd,
  input  logic              cmd_bus_ack,
  input  logic [DATA_W-1:0] cmd_bus_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  timeout_cnt,
  output logic [CNT_W-1:0]  late_cnt
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT,
    S_ISSUE
  } state_t;

  state_t            state_q, state_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              rd_en_q, rd_en_d;
  logic              reset_time_q, reset_time_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              stop_pend_q, stop_pend_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]  timeout_cnt_q, timeout_cnt_d;

  logic [TIME_W-1:0] cmd_time;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              stop_any;
  logic              issue;

  assign cmd_time = cmd_q[CMD_W-1 -: TIME_W];
  assign cmd_op   = cmd_q[ADDR_W+DATA_W];
  assign cmd_addr = cmd_q[DATA_W +: ADDR_W];
  assign cmd_data = cmd_q[DATA_W-1:0];
  assign stop_any = stop | stop_pend_q;

`ifdef TIMED_CMD_SCHED_LATE_DROP_EN
  logic              first_wait_q, first_wait_d;
  logic [CNT_W-1:0]  late_cnt_q, late_cnt_d;
  logic [TIME_W-1:0] slack_diff;
  logic              is_late;

  assign slack_diff = current_time - cmd_time;
  assign is_late    = (current_time >= cmd_time) && (slack_diff > TIME_W'(LATE_SLACK));
`endif

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    rd_en_d       = 1'b0;
    reset_time_d  = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    to_cnt_d      = '0;
    timeout_cnt_d = timeout_cnt_q;
    stop_pend_d   = stop_pend_q | (stop && (state_q != S_IDLE));
`ifdef TIMED_CMD_SCHED_LATE_DROP_EN
    late_cnt_d    = late_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!stop && start) begin
          reset_time_d = 1'b1;
          state_d      = S_FETCH;
        end
      end

      // A pop issued in this cycle must be followed through, even if stop arrives now.
      S_FETCH: begin
        if (rd_en_q) begin
          state_d = S_LOAD;
        end else if (stop_any) begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        if (cmd_fifo_valid) begin
          cmd_d   = cmd_fifo_dout;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (stop_any) begin
          state_d = S_IDLE;
`ifdef TIMED_CMD_SCHED_LATE_DROP_EN
        end else if (first_wait_q && is_late) begin
          if (late_cnt_q != {CNT_W{1'b1}}) begin
            late_cnt_d = late_cnt_q + CNT_W'(1);
          end
          state_d = S_FETCH;
`endif
        end else if (current_time >= cmd_time) begin
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (cmd_bus_ack) begin
          if (cmd_op) begin
            rdata_d       = cmd_bus_rdata;
            rdata_valid_d = 1'b1;
          end
          state_d = S_FETCH;
        end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
          if (timeout_cnt_q != {CNT_W{1'b1}}) begin
            timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
          end
          state_d = S_FETCH;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) begin
      stop_pend_d = 1'b0;
    end

    // The pop is decided one cycle ahead so rd_en comes straight from a register;
    // only this block pops the FIFO, so a non-empty sample cannot go stale.
    rd_en_d = (state_d == S_FETCH) && (state_q != S_FETCH || !rd_en_q) &&
              !cmd_fifo_empty && !stop && !stop_pend_q;
  end

`ifdef TIMED_CMD_SCHED_LATE_DROP_EN
  assign first_wait_d = (state_d == S_WAIT) && (state_q != S_WAIT);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cmd_q         <= '0;
      rd_en_q       <= 1'b0;
      reset_time_q  <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      stop_pend_q   <= 1'b0;
      to_cnt_q      <= '0;
      timeout_cnt_q <= '0;
`ifdef TIMED_CMD_SCHED_LATE_DROP_EN
      first_wait_q  <= 1'b0;
      late_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      rd_en_q       <= rd_en_d;
      reset_time_q  <= reset_time_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      stop_pend_q   <= stop_pend_d;
      to_cnt_q      <= to_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
`ifdef TIMED_CMD_SCHED_LATE_DROP_EN
      first_wait_q  <= first_wait_d;
      late_cnt_q    <= late_cnt_d;
`endif
    end
  end

  assign issue          = (state_q == S_ISSUE);
  assign cmd_bus_en     = issue;
  assign cmd_bus_wr     = issue && !cmd_op;
  assign cmd_bus_rd     = issue && cmd_op;
  assign cmd_bus_addr   = issue ? cmd_addr : '0;
  assign cmd_bus_data   = issue ? cmd_data : '0;
  assign cmd_fifo_rd_en = rd_en_q;
  assign reset_time     = reset_time_q;
  assign rdata          = rdata_q;
  assign rdata_valid    = rdata_valid_q;
  assign busy           = (state_q != S_IDLE);
  assign timeout_cnt    = timeout_cnt_q;
`ifdef TIMED_CMD_SCHED_LATE_DROP_EN
  assign late_cnt       = late_cnt_q;
`else
  assign late_cnt       = '0;
`endif

endmodule

// File: tb/tb_timed_cmd_scheduler.sv
// Directed bench for timed_cmd_scheduler: FIFO and timer models, hand-computed expectations.
module tb_timed_cmd_scheduler;

  localparam int TW = 32;
  localparam int AW = 19;
  localparam int DW = 16;
  localparam int CW = TW + 1 + AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [TW-1:0] ct = '0;
  logic          reset_time;
  logic [CW-1:0] fifo_dout = '0;
  logic          fifo_empty;
  logic          fifo_valid = 1'b0;
  logic          fifo_rd_en;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_data;
  logic          bus_en;
  logic          bus_wr;
  logic          bus_rd;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          busy;
  logic [15:0]   timeout_cnt;
  logic [15:0]   late_cnt;

  logic [CW-1:0] mem [0:31];
  logic [4:0]    wr_ptr = '0;
  logic [4:0]    rd_ptr = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  timed_cmd_scheduler #(
    .ACK_TIMEOUT(4)
`ifdef TIMED_CMD_SCHED_LATE_DROP_EN
    , .LATE_SLACK(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .current_time(ct), .reset_time(reset_time),
    .cmd_fifo_dout(fifo_dout), .cmd_fifo_empty(fifo_empty),
    .cmd_fifo_valid(fifo_valid), .cmd_fifo_rd_en(fifo_rd_en),
    .cmd_bus_addr(bus_addr), .cmd_bus_data(bus_data), .cmd_bus_en(bus_en),
    .cmd_bus_wr(bus_wr), .cmd_bus_rd(bus_rd), .cmd_bus_ack(bus_ack),
    .cmd_bus_rdata(bus_rdata), .rdata(rdata), .rdata_valid(rdata_valid),
    .busy(busy), .timeout_cnt(timeout_cnt), .late_cnt(late_cnt)
  );

  // Free-running timer zeroed by the scheduler's pulse.
  always @(posedge clk) begin
    if (reset_time) ct <= '0;
    else            ct <= ct + 1;
  end

  // FIFO model: data valid one cycle after the pop.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    fifo_valid <= 1'b0;
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout  <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
      fifo_valid <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [TW-1:0] t, input logic op, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    mem[wr_ptr] = {t, op, a, d};
    wr_ptr      = wr_ptr + 1;
    $display("txn push time=%0d op=%0d addr=%0h data=%0h at ct=%0d", t, op, a, d, ct);
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (bus_en !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < 2000, 1);
  endtask

  task automatic wait_pop(input string tag);
    int n = 0;
    while (fifo_rd_en !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < 200, 1);
  endtask

  task automatic ack_now(input logic [DW-1:0] rd);
    bus_ack   = 1'b1;
    bus_rdata = rd;
    $display("txn ack addr=%0h wr=%0d rd=%0d at ct=%0d", bus_addr, bus_wr, bus_rd, ct);
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = '0;
  endtask

  task automatic wait_ct(input logic [TW-1:0] t);
    int n = 0;
    while (ct < t && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ct_bound", n < 500, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    int lat;
    logic seen;
    logic [TW-1:0] t0;

    rst = 1'b1; start = 1'b0; stop = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_reset_time", reset_time, 0);
    chk("rst_bus_en", bus_en, 0);
    chk("rst_bus_strobes", {bus_wr, bus_rd, fifo_rd_en}, 0);
    chk("rst_bus_addr_data", {bus_addr, bus_data}, 0);
    chk("rst_rdata", {rdata, rdata_valid}, 0);
    chk("rst_counters", {timeout_cnt, late_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Start: one reset_time pulse, then quiet bus while the FIFO is empty.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_reset_time", reset_time, 1);
    chk("start_busy", busy, 1);
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (reset_time) cnt++;
      if (bus_en || bus_wr || bus_rd || fifo_rd_en) seen = 1'b1;
    end
    chk("reset_time_extra_cycles", cnt, 0);
    chk("empty_fifo_bus_quiet", seen, 0);

    // Read with a past timestamp, acked in the first ISSUE cycle.
    push(32'd5, 1'b1, 19'h7, 16'h0);
    wait_en("read_issue_seen");
    chk("read_strobes", {bus_rd, bus_wr}, 2'b10);
    chk("read_addr", bus_addr, 19'h7);
    ack_now(16'h1234);
    chk("read_done_en", bus_en, 0);
    chk("read_rdata", rdata, 16'h1234);
    chk("read_rdata_valid", rdata_valid, 1);
    @(negedge clk);
    chk("read_rdata_valid_pulse", rdata_valid, 0);

    // Write at time 100, acked in the second ISSUE cycle.
    push(32'd100, 1'b0, 19'h12, 16'hBEEF);
    wait_en("write_issue_seen");
    chk("write_en_after_match", ct, 101);
    chk("write_strobes", {bus_wr, bus_rd}, 2'b10);
    chk("write_addr_data", {bus_addr, bus_data}, {19'h12, 16'hBEEF});
    @(negedge clk);
    chk("write_held", {bus_en, bus_addr, bus_data}, {1'b1, 19'h12, 16'hBEEF});
    ack_now(16'h0);
    chk("write_done_strobes", {bus_en, bus_wr}, 0);
    chk("write_no_rdata_valid", rdata_valid, 0);
    chk("write_keeps_rdata", rdata, 16'h1234);
    chk("write_busy_fetch", busy, 1);

    // Read that never gets an ack: 4 ISSUE cycles, then abort.
    push(ct, 1'b1, 19'h55, 16'h0);
    wait_pop("timeout_pop_seen");
    lat = 0;
    while (bus_en !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("pop_to_en_latency", lat, 3);
    cnt = 0; seen = 1'b0;
    while (bus_en === 1'b1 && cnt < 20) begin
      cnt++;
      if (rdata_valid) seen = 1'b1;
      @(negedge clk);
    end
    if (rdata_valid) seen = 1'b1;
    chk("timeout_en_cycles", cnt, 4);
    chk("timeout_no_rdata_valid", seen, 0);
    chk("timeout_cnt_inc", timeout_cnt, 1);
    chk("timeout_keeps_rdata", rdata, 16'h1234);
    $display("txn timeout addr=55 timeout_cnt=%0d", timeout_cnt);

    // Two commands with equal timestamps: 3 idle bus cycles between them.
    t0 = ct;
    push(t0, 1'b0, 19'h66, 16'h1111);
    push(t0, 1'b0, 19'h67, 16'h2222);
    wait_en("b2b_first_seen");
    chk("b2b_first_addr", bus_addr, 19'h66);
    ack_now(16'h0);
    cnt = 0;
    while (bus_en !== 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("b2b_idle_gap", cnt, 3);
    chk("b2b_second_addr_data", {bus_addr, bus_data}, {19'h67, 16'h2222});
    ack_now(16'h0);
    chk("b2b_done_en", bus_en, 0);

    // Stop while waiting for a far timestamp: command dropped, no bus cycle.
    push(ct + 32'd1000, 1'b0, 19'h99, 16'h0);
    wait_pop("stop_wait_pop_seen");
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_wait_idle", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_en || busy) seen = 1'b1;
    end
    chk("stop_wait_no_issue", seen, 0);

    // Restart, then stop during ISSUE: cycle completes on ack, then IDLE.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_reset_time", reset_time, 1);
    push(32'd0, 1'b0, 19'h21, 16'h2121);
    wait_en("stop_issue_seen");
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_ignored_in_issue", {bus_en, bus_addr}, {1'b1, 19'h21});
    push(32'd0, 1'b0, 19'h42, 16'h4242);
    @(negedge clk);
    seen = fifo_rd_en;
    ack_now(16'h0);
    seen = seen | fifo_rd_en;
    chk("stop_issue_done_en", bus_en, 0);
    chk("stop_issue_fetch_busy", busy, 1);
    @(negedge clk);
    seen = seen | fifo_rd_en;
    chk("stop_issue_idle", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | fifo_rd_en;
    end
    chk("stop_pending_no_pop", seen, 0);

    // Restart drains the queued command.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_en("queued_cmd_seen");
    chk("queued_cmd_addr_data", {bus_addr, bus_data}, {19'h42, 16'h4242});
    ack_now(16'h0);

    // Late command: time 10 loaded around current_time 48.
    wait_ct(32'd45);
    push(32'd10, 1'b0, 19'h31, 16'h3131);
`ifdef TIMED_CMD_SCHED_LATE_DROP_EN
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_en) seen = 1'b1;
    end
    chk("late_not_issued", seen, 0);
    chk("late_cnt_inc", late_cnt, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ct(32'd45);
    push(32'd40, 1'b0, 19'h32, 16'h3232);
    wait_en("within_slack_seen");
    chk("within_slack_addr", bus_addr, 19'h32);
    ack_now(16'h0);
    chk("late_cnt_hold", late_cnt, 1);
`else
    wait_en("late_issued_seen");
    chk("late_issued_addr", bus_addr, 19'h31);
    ack_now(16'h0);
    chk("late_cnt_zero", late_cnt, 0);
`endif
    chk("timeout_cnt_final", timeout_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
